// File: rtl/pc_run_controller.sv
// Button conditioner: two-flop synchronizer plus run-length debounce, 1-cycle pulse on accepted rise.
// Latency: raw rise sampled at edge k gives a pulse in the cycle after edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; a held button yields exactly one pulse, a release yields none.
module pc_run_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    // Last count value before a disagreeing level is accepted (DEBOUNCE_CYCLES is 1..255).
    localparam logic [7:0] COUNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync_meta;
    logic       sync_level;
    logic       accepted;
    logic [7:0] run_count;
    logic       mismatch;
    logic       take;

    assign mismatch = (sync_level != accepted);
    assign take     = mismatch && (run_count == COUNT_LAST);

    // Two-flop synchronizer for the asynchronous front-panel input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
        end
    end

    // Count consecutive samples disagreeing with the accepted level; an agreeing sample restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_count <= 8'd0;
            accepted  <= 1'b0;
        end else if (!mismatch) begin
            run_count <= 8'd0;
        end else if (take) begin
            run_count <= 8'd0;
            accepted  <= sync_level;
        end else begin
            run_count <= run_count + 8'd1;
        end
    end

    // Single-cycle pulse only when a new high level is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= take && sync_level;
        end
    end
endmodule

// Run/halt/single-step sequencer producing the global enable for the single-cycle CPU.
// Latency: syscall-halt and breakpoint drop enable in the same cycle; buttons act one cycle after their pulse.
// Backpressure: enable is the only throttle; while it is low the PC and all architectural state hold.
module pc_run_controller #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        halt,
    input  logic        go,
    input  logic        step,
    input  logic        bpEnable,
    input  logic [31:0] bpAddress,
    output logic        enable,
    output logic [1:0]  state,
    output logic [1:0]  haltReason,
    output logic [31:0] haltCount,
    output logic [31:0] haltedCycles
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2,
        ST_RESUME = 2'd3
    } run_state_t;

    localparam logic [1:0] REASON_NONE    = 2'd0;
    localparam logic [1:0] REASON_SYSCALL = 2'd1;
    localparam logic [1:0] REASON_BREAK   = 2'd2;
    localparam logic [1:0] REASON_MANUAL  = 2'd3;

    run_state_t  cur_state;
    run_state_t  nxt_state;
    logic [1:0]  reason_q;
    logic [1:0]  nxt_reason;
    logic [31:0] halt_count_q;
    logic [31:0] halted_cycles_q;
    logic        go_pulse;
    logic        step_pulse;
    logic        bp_hit;
    logic        halt_event;
    logic        run_enable;

    pc_run_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (go),
        .pulse (go_pulse)
    );

    pc_run_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (step),
        .pulse (step_pulse)
    );

    assign bp_hit = bpEnable && (pc == bpAddress);

    // Next state, halt reason and enable; the offending instruction is never clocked in RUN.
    always_comb begin
        nxt_state  = cur_state;
        nxt_reason = reason_q;
        halt_event = 1'b0;
        run_enable = 1'b0;
        case (cur_state)
            ST_RUN: begin
                if (halt) begin
                    nxt_state  = ST_HALTED;
                    nxt_reason = REASON_SYSCALL;
                    halt_event = 1'b1;
                end else if (bp_hit) begin
                    nxt_state  = ST_HALTED;
                    nxt_reason = REASON_BREAK;
                    halt_event = 1'b1;
                end else if (go_pulse) begin
                    nxt_state  = ST_HALTED;
                    nxt_reason = REASON_MANUAL;
                    halt_event = 1'b1;
                end else begin
                    run_enable = 1'b1;
                end
            end
            ST_HALTED: begin
                if (go_pulse) begin
                    nxt_state = ST_RESUME;
                end else if (step_pulse) begin
                    nxt_state = ST_STEP;
                end
            end
            ST_STEP: begin
                run_enable = 1'b1;
                nxt_state  = ST_HALTED;
            end
            ST_RESUME: begin
                run_enable = 1'b1;
                nxt_state  = ST_RUN;
                nxt_reason = REASON_NONE;
            end
            default: begin
                nxt_state  = ST_RUN;
                nxt_reason = REASON_NONE;
            end
        endcase
    end

    // State and halt-reason registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= ST_RUN;
            reason_q  <= REASON_NONE;
        end else begin
            cur_state <= nxt_state;
            reason_q  <= nxt_reason;
        end
    end

    // Halt statistics; both counters wrap freely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            halt_count_q    <= 32'd0;
            halted_cycles_q <= 32'd0;
        end else begin
            if (halt_event) begin
                halt_count_q <= halt_count_q + 32'd1;
            end
            if (cur_state == ST_HALTED) begin
                halted_cycles_q <= halted_cycles_q + 32'd1;
            end
        end
    end

    // Reset forces enable low so the PC takes its own reset path.
    assign enable       = run_enable && !reset;
    assign state        = cur_state;
    assign haltReason   = reason_q;
    assign haltCount    = halt_count_q;
    assign haltedCycles = halted_cycles_q;
endmodule

// File: doc/pc_run_controller.md
Name: pc_run_controller

Overview:
- Run/halt/single-step sequencer for the single-cycle CPU.
- Generates the global `enable` that gates the PC and all architectural state.
- Halts on a decoded syscall-halt, a PC breakpoint match or a manual pause, and resumes or single-steps from debounced front-panel buttons.
- Keeps halt statistics alongside the PC's cycle/jump counters.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive equal synchronized samples required before a button level is accepted (range 1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pc  in  32  current PC value
- halt  in  1  decoder flag: instruction at `pc` is syscall-halt (combinational, same cycle)
- go  in  1  raw, asynchronous resume/pause button
- step  in  1  raw, asynchronous single-step button
- bpEnable  in  1  breakpoint enable
- bpAddress  in  32  breakpoint PC; held stable by software/switches
- enable  out  1  clock enable for PC, register file and memory writes
- state  out  2  FSM state encoding
- haltReason  out  2  0 none, 1 syscall, 2 breakpoint, 3 manual
- haltCount  out  32  number of RUN->HALTED transitions
- haltedCycles  out  32  clock cycles spent in HALTED

Behaviour:
- Reset (async, active-high):
  - state=RUN, haltReason=0, counters=0.
  - Synchronizers, debounce counters and accepted levels cleared to 0.
  - `enable` is forced 0 while reset is high, so the PC sees its reset path.
- Button path, identical for go and step:
  - 2-flop synchronizer, then a debounce counter.
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive samples differing from it; any mismatch-free break restarts the count.
  - goPulse/stepPulse is a 1-cycle pulse on an accepted 0->1 change.
  - Latency: raw rise sampled at edge k gives a pulse high in the cycle after edge k+1+DEBOUNCE_CYCLES.
  - Release is debounced the same way and produces no pulse.
- bpHit = bpEnable && (pc == bpAddress), full 32-bit compare.
- enable is combinational: (state==RUN && !halt && !bpHit && !goPulse) || state==STEP || state==RESUME, and is 0 during reset.
- States:
  - RUN (0):
    - halt -> HALTED, reason 1.
    - else bpHit -> HALTED, reason 2.
    - else goPulse -> HALTED, reason 3.
    - In all three cases enable=0 that cycle, so the PC holds on the offending instruction.
    - Priority is syscall > breakpoint > manual; haltCount += 1 on each of these transitions.
    - stepPulse is ignored.
  - HALTED (1):
    - enable=0; haltedCycles += 1 every cycle.
    - goPulse -> RESUME.
    - else stepPulse -> STEP.
    - go wins if both pulse in the same cycle.
    - haltReason is held.
  - STEP (2):
    - Exactly one cycle with enable=1; halt and bpHit are ignored.
    - Next state HALTED; haltReason unchanged.
    - haltCount is not incremented.
  - RESUME (3):
    - Exactly one cycle with enable=1; halt and bpHit are ignored, so execution leaves the halt/breakpoint instruction.
    - Next state RUN; haltReason cleared to 0.
- Counters wrap modulo 2^32 and are never saturated.
- Reset mid-STEP/RESUME: immediate return to RUN with enable=0; no partial step is counted.
- Button held continuously produces one pulse only.
- Breakpoint at the current PC after RESUME: that instruction executes once; the breakpoint re-arms when PC returns to it later.

Test Plan (DEBOUNCE_CYCLES=2):
- Reset released, pc increments 0,4,8, halt=1 at pc=0x0C -> enable=0 same cycle, state=1, haltReason=1, haltCount=1; pc stays 0x0C.
- Halted at 0x0C, step raw high for 10 cycles -> exactly one enable=1 cycle 4 edges after the rise; state back to 1; pc=0x10; haltCount still 1.
- Halted, go pressed -> one RESUME cycle, then state=0, haltReason=0; halt at pc=0x0C is not re-triggered on the resume cycle.
- bpEnable=1, bpAddress=0x20 -> halt with enable=0 while pc=0x20, haltReason=2. If halt=1 coincides at 0x20 -> haltReason=1.
- In RUN, glitch on go high for 1 cycle -> no pulse, no halt. Go held for 6 cycles -> manual halt, reason 3. Go and step pulses aligned in HALTED -> RESUME chosen.
- Halted for 100 cycles -> haltedCycles=100. Assert reset during STEP -> state=0, counters=0, enable=0 while reset is high.
